git_op_sequencer: RTL and testbench

- Sequences git-workflow operations (clone, status, add, add-all, commit, pull, stash, push) against the 45-bit session/learning datapath.
- Accepts one command at a time over a valid/ready handshake and tracks repository state: cloned flag, staged count, commits-ahead count.
- Drives the datapath control strobes (repo_generation, access_to_batch, clonning_using_address, push_to_repo).
- Returns one response per command over a second valid/ready handshake.

---
 rtl/git_op_pkg.sv | 30 +++
 rtl/git_sat_cnt.sv | 32 +++
 rtl/git_op_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_git_op_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/git_op_pkg.sv
// Shared types and constants for the git operation sequencer.
package git_op_pkg;

  localparam int DATA_W_DEF = 45;
  localparam int CNT_W_DEF  = 8;

  // STATUS payload layout: {cloned, staged_cnt, ahead_cnt}, ahead_cnt in the LSBs
  localparam int STAT_AHEAD_LSB  = 0;
  localparam int STAT_STAGED_LSB = CNT_W_DEF;
  localparam int STAT_CLONED_BIT = 2 * CNT_W_DEF;

  typedef enum logic [2:0] {
    OP_CLONE   = 3'd0,
    OP_STATUS  = 3'd1,
    OP_ADD     = 3'd2,
    OP_ADD_ALL = 3'd3,
    OP_COMMIT  = 3'd4,
    OP_PULL    = 3'd5,
    OP_STASH   = 3'd6,
    OP_PUSH    = 3'd7
  } git_op_e;

  typedef enum logic [1:0] {
    ST_NOCLONE = 2'd0,
    ST_READY   = 2'd1,
    ST_EXEC    = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/git_sat_cnt.sv
// Saturating counter with add, clear and load; load wins over clear, clear over add.
module git_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] add_val,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W:0] sum_s;

  assign sum_s = {1'b0, cnt} + {1'b0, add_val};

  // Counter register; a carry out of the add saturates to all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (add) begin
      cnt <= sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/git_op_sequencer.sv
// Git workflow command sequencer with repository state tracking.
// Optional stash support is enabled by defining GIT_STASH_EN.
module git_op_sequencer
  import git_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int OP_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              repo_generation,
  output logic              access_to_batch,
  output logic              clonning_using_address,
  output logic              push_to_repo,
  output logic [CNT_W-1:0]  staged_cnt,
  output logic [CNT_W-1:0]  ahead_cnt
);

  seq_state_e        state_r, state_nxt_s;
  logic [3:0]        wait_r;
  git_op_e           op_r;
  logic [DATA_W-1:0] data_r;
  logic              err_r;
  logic              cloned_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_err_r;
  logic              access_r;
  logic              clone_pulse_r;
  logic              push_pulse_r;

  logic              accept_s, exec_done_s, fire_s, legal_s, batch_op_s;
  logic [DATA_W-1:0] status_s;
  logic              staged_clr_s, staged_add_s, staged_load_s;
  logic [CNT_W-1:0]  staged_add_val_s, staged_load_val_s;
  logic              ahead_clr_s, ahead_add_s;

`ifdef GIT_STASH_EN
  logic              stash_clr_s, stash_load_s;
  logic [CNT_W-1:0]  stash_cnt_s;
`endif

  assign cmd_ready              = (state_r == ST_NOCLONE) || (state_r == ST_READY);
  assign rsp_valid              = (state_r == ST_RESP);
  assign rsp_data               = rsp_data_r;
  assign rsp_err                = rsp_err_r;
  assign repo_generation        = cloned_r;
  assign access_to_batch        = access_r;
  assign clonning_using_address = clone_pulse_r;
  assign push_to_repo           = push_pulse_r;

  assign accept_s    = cmd_valid && cmd_ready;
  assign exec_done_s = (state_r == ST_EXEC) && (wait_r == 4'(OP_LAT - 1));
  assign fire_s      = exec_done_s && !err_r;
  assign batch_op_s  = (cmd_op == OP_ADD) || (cmd_op == OP_ADD_ALL) || (cmd_op == OP_COMMIT);

  // STATUS payload assembly
  always_comb begin
    status_s                                = '0;
    status_s[STAT_AHEAD_LSB +: CNT_W]       = ahead_cnt;
    status_s[STAT_STAGED_LSB +: CNT_W]      = staged_cnt;
    status_s[STAT_CLONED_BIT]               = cloned_r;
  end

  // Legality of the offered command against current repository state
  always_comb begin
    legal_s = 1'b0;
    case (git_op_e'(cmd_op))
      OP_CLONE:   legal_s = !cloned_r;
      OP_STATUS:  legal_s = cloned_r;
      OP_ADD:     legal_s = cloned_r;
      OP_ADD_ALL: legal_s = cloned_r;
      OP_COMMIT:  legal_s = cloned_r && (staged_cnt != '0);
      OP_PULL:    legal_s = cloned_r && (ahead_cnt == '0);
`ifdef GIT_STASH_EN
      OP_STASH:   legal_s = cloned_r && (((staged_cnt != '0) && (stash_cnt_s == '0)) ||
                                         ((staged_cnt == '0) && (stash_cnt_s != '0)));
`else
      OP_STASH:   legal_s = 1'b0;
`endif
      OP_PUSH:    legal_s = cloned_r && (ahead_cnt != '0);
      default:    legal_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_NOCLONE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_NOCLONE, ST_READY: begin
        if (accept_s) state_nxt_s = ST_EXEC;
        else          state_nxt_s = state_r;
      end
      ST_EXEC: begin
        if (exec_done_s) state_nxt_s = ST_RESP;
        else             state_nxt_s = ST_EXEC;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt_s = cloned_r ? ST_READY : ST_NOCLONE;
        else           state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_NOCLONE;
    endcase
  end

  // Counter controls; effects land on the final EXEC cycle only
  always_comb begin
    staged_clr_s      = 1'b0;
    staged_add_s      = 1'b0;
    staged_add_val_s  = '0;
    staged_load_s     = 1'b0;
    staged_load_val_s = '0;
    ahead_clr_s       = 1'b0;
    ahead_add_s       = 1'b0;
`ifdef GIT_STASH_EN
    stash_clr_s       = 1'b0;
    stash_load_s      = 1'b0;
`endif
    if (fire_s) begin
      case (op_r)
        OP_ADD: begin
          staged_add_s     = 1'b1;
          staged_add_val_s = CNT_W'(1);
        end
        OP_ADD_ALL: begin
          staged_add_s     = 1'b1;
          staged_add_val_s = data_r[CNT_W-1:0];
        end
        OP_COMMIT: begin
          staged_clr_s = 1'b1;
          ahead_add_s  = 1'b1;
        end
        OP_PUSH: ahead_clr_s = 1'b1;
`ifdef GIT_STASH_EN
        OP_STASH: begin
          if (staged_cnt != '0) begin
            stash_load_s = 1'b1;
            staged_clr_s = 1'b1;
          end else begin
            staged_load_s     = 1'b1;
            staged_load_val_s = stash_cnt_s;
            stash_clr_s       = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end else begin
      staged_add_s = 1'b0;
    end
  end

  // Command capture, wait counter, response and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_r        <= 4'd0;
      op_r          <= OP_CLONE;
      data_r        <= '0;
      err_r         <= 1'b0;
      cloned_r      <= 1'b0;
      rsp_data_r    <= '0;
      rsp_err_r     <= 1'b0;
      access_r      <= 1'b0;
      clone_pulse_r <= 1'b0;
      push_pulse_r  <= 1'b0;
    end else begin
      clone_pulse_r <= fire_s && (op_r == OP_CLONE);
      push_pulse_r  <= fire_s && (op_r == OP_PUSH);
      if (accept_s) begin
        op_r     <= git_op_e'(cmd_op);
        data_r   <= cmd_data;
        err_r    <= !legal_s;
        access_r <= legal_s && batch_op_s;
        wait_r   <= 4'd0;
      end else if (state_r == ST_EXEC) begin
        wait_r <= wait_r + 4'd1;
      end
      if (exec_done_s) begin
        access_r  <= 1'b0;
        rsp_err_r <= err_r;
        if (err_r)                  rsp_data_r <= '0;
        else if (op_r == OP_STATUS) rsp_data_r <= status_s;
        else                        rsp_data_r <= data_r;
        if (fire_s && (op_r == OP_CLONE)) cloned_r <= 1'b1;
      end else if ((state_r == ST_RESP) && rsp_ready) begin
        rsp_data_r <= '0;
        rsp_err_r  <= 1'b0;
      end
    end
  end

  git_sat_cnt #(.W(CNT_W)) u_staged (
    .clk(clk), .rst_n(rst_n), .clr(staged_clr_s), .add(staged_add_s),
    .add_val(staged_add_val_s), .load(staged_load_s), .load_val(staged_load_val_s),
    .cnt(staged_cnt)
  );

  git_sat_cnt #(.W(CNT_W)) u_ahead (
    .clk(clk), .rst_n(rst_n), .clr(ahead_clr_s), .add(ahead_add_s),
    .add_val(CNT_W'(1)), .load(1'b0), .load_val({CNT_W{1'b0}}),
    .cnt(ahead_cnt)
  );

`ifdef GIT_STASH_EN
  git_sat_cnt #(.W(CNT_W)) u_stash (
    .clk(clk), .rst_n(rst_n), .clr(stash_clr_s), .add(1'b0),
    .add_val({CNT_W{1'b0}}), .load(stash_load_s), .load_val(staged_cnt),
    .cnt(stash_cnt_s)
  );
`endif

endmodule

// File: tb/tb_git_op_sequencer.sv
// Scoreboard bench for git_op_sequencer: random and directed commands vs a reference model.
module tb_git_op_sequencer;

  localparam int OP_LAT = 3;
  localparam int MAXC   = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [44:0] cmd_data = 45'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [44:0] rsp_data;
  logic        rsp_err;
  logic        repo_generation, access_to_batch, clonning_using_address, push_to_repo;
  logic [7:0]  staged_cnt, ahead_cnt;

  git_op_sequencer #(.DATA_W(45), .CNT_W(8), .OP_LAT(OP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .repo_generation(repo_generation),
    .access_to_batch(access_to_batch), .clonning_using_address(clonning_using_address),
    .push_to_repo(push_to_repo), .staged_cnt(staged_cnt), .ahead_cnt(ahead_cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [44:0] data;
    logic        err;
    int          staged, ahead, cloned;
    int          clone_p, push_p, acc;
    longint      acc_cyc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int stall   = 0;
  int m_cloned = 0, m_staged = 0, m_ahead = 0, m_stash = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Reference model: apply the command's rules to the abstract repository state
  task automatic model(input logic [2:0] op, input logic [44:0] d, input bit commit, output exp_t e);
    int cl = m_cloned, st = m_staged, ah = m_ahead, sh = m_stash;
    logic [7:0] cnt8;
    bit err = 0;
    e.data = d; e.clone_p = 0; e.push_p = 0; e.acc = 0; e.acc_cyc = 0;
    cnt8 = d[7:0];
    if (op == 3'd0) begin
      if (cl != 0) err = 1; else begin cl = 1; e.clone_p = 1; end
    end else if (cl == 0) begin
      err = 1;
    end else begin
      case (op)
        3'd1: e.data = 45'((1 << 16) + (st << 8) + ah);
        3'd2: st = sat(st + 1);
        3'd3: st = sat(st + int'(cnt8));
        3'd4: if (st == 0) err = 1; else begin st = 0; ah = sat(ah + 1); end
        3'd5: if (ah > 0) err = 1;
`ifdef GIT_STASH_EN
        3'd6: begin
          if (st > 0 && sh == 0) begin sh = st; st = 0; end
          else if (st == 0 && sh > 0) begin st = sh; sh = 0; end
          else err = 1;
        end
`else
        3'd6: err = 1;
`endif
        default: if (ah == 0) err = 1; else begin ah = 0; e.push_p = 1; end
      endcase
    end
    if (err) e.data = 45'd0;
    e.err = err;
    e.acc = (!err && (op == 3'd2 || op == 3'd3 || op == 3'd4)) ? OP_LAT : 0;
    e.staged = st; e.ahead = ah; e.cloned = cl;
    if (commit) begin m_cloned = cl; m_staged = st; m_ahead = ah; m_stash = sh; end
  endtask

  task automatic issue(input logic [2:0] op, input logic [44:0] d, input bit track);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    model(op, d, track, e);
    e.acc_cyc = cyc;
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);
    cmd_data = 45'($urandom);
  endtask

  // Consumer back-pressure: random, with forced stall windows
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin rsp_ready = 1'b0; stall--; end
      else rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, hold stability, payload and strobe counts per response
  initial begin
    bit pv = 0;
    logic [44:0] hd = '0;
    logic he = 1'b0;
    int ncl = 0, npu = 0, nac = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; ncl = 0; npu = 0; nac = 0;
      end else begin
        ncl += int'(clonning_using_address);
        npu += int'(push_to_repo);
        nac += int'(access_to_batch);
        if (rsp_valid) begin
          chk("cmd_ready_in_resp", {63'd0, cmd_ready}, 64'd0);
          if (pv) begin
            chk("rsp_hold_data", 64'(rsp_data), 64'(hd));
            chk("rsp_hold_err", {63'd0, rsp_err}, {63'd0, he});
          end else if (sb.size() == 0) begin
            chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
          end else begin
            chk("rsp_latency", 64'(cyc - sb[0].acc_cyc), 64'(OP_LAT + 1));
          end
          if (rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            chk("staged_cnt", 64'(staged_cnt), 64'(e.staged));
            chk("ahead_cnt", 64'(ahead_cnt), 64'(e.ahead));
            chk("repo_generation", {63'd0, repo_generation}, 64'(e.cloned));
            chk("clone_pulse_cycles", 64'(ncl), 64'(e.clone_p));
            chk("push_pulse_cycles", 64'(npu), 64'(e.push_p));
            chk("access_cycles", 64'(nac), 64'(e.acc));
            ncl = 0; npu = 0; nac = 0; pv = 0;
          end else begin
            pv = !rsp_ready; hd = rsp_data; he = rsp_err;
          end
        end else begin
          pv = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctrl"}, {57'd0, cmd_ready, rsp_valid, rsp_err, repo_generation,
         access_to_batch, clonning_using_address, push_to_repo}, 64'h40);
    chk({nm, "_cnt"}, {48'd0, staged_cnt, ahead_cnt}, 64'd0);
    chk({nm, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    logic [63:0] r64;
    int n;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(3'd1, 45'd0, 1);                  // STATUS before clone
    issue(3'd0, 45'h1234, 1);               // CLONE
    issue(3'd0, 45'h55, 1);                 // second CLONE
    issue(3'd2, 45'd0, 1);                  // ADD
    issue(3'd3, 45'd5, 1);                  // ADD_ALL(5)
    issue(3'd4, 45'd0, 1);                  // COMMIT
    issue(3'd1, 45'd0, 1);                  // STATUS -> 0x10001
    issue(3'd5, 45'h77, 1);                 // PULL with ahead>0
    issue(3'd7, 45'h88, 1);                 // PUSH
    issue(3'd5, 45'h99, 1);                 // PULL ok
    issue(3'd3, 45'd250, 1);
    issue(3'd3, 45'd250, 1);                // saturates at 255
    stall = OP_LAT + 5;
    issue(3'd4, 45'd0, 1);                  // COMMIT with held response
    issue(3'd3, 45'h1F_0000_0000, 1);       // ADD_ALL with zero count
`ifdef GIT_STASH_EN
    issue(3'd3, 45'd3, 1);
    issue(3'd6, 45'd0, 1);                  // stash push
    issue(3'd6, 45'd0, 1);                  // stash pop -> staged 3
    issue(3'd6, 45'd0, 1);                  // push again
    issue(3'd6, 45'd0, 1);
    issue(3'd1, 45'd0, 1);
`else
    issue(3'd6, 45'd0, 1);
`endif

    // Reset during EXEC: command and response are dropped
    n = 0;
    while (sb.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    issue(3'd2, 45'd0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midexec_reset");
    m_cloned = 0; m_staged = 0; m_ahead = 0; m_stash = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 45'd0, 1);
    issue(3'd0, 45'h1ABC_DEF0_1234, 1);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [44:0] d;
      op = 3'($urandom_range(1, 7));
      r64 = {$urandom(), $urandom()};
      d = r64[44:0];
      if (op == 3'd3 && $urandom_range(0, 3) != 0) d = 45'($urandom_range(0, 6));
      issue(op, d, 1);
    end

    n = 0;
    while (sb.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
